// File: rtl/bidi_stack_register.sv
// Bus-attached LIFO on the shared tristate data bus.
// A bus write pushes a word; a bus read pops it, or peeks at it when PEEK is high.
module bidi_stack_register #(
  parameter int BUS_WIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 RW,
  input  logic                 ENABLE,
  input  logic                 PEEK,
  input  logic                 CLEAR_ERR,
  inout  wire  [BUS_WIDTH-1:0] DATA,
  output logic [BUS_WIDTH-1:0] TOP,
  output logic [PTR_WIDTH-1:0] LEVEL,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LVL_MAX = PTR_WIDTH'(DEPTH);

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] level_q;
  logic                 ovf_q;
  logic                 unf_q;

  logic          push;
  logic          pop;
  logic          peek;
  logic          rd_en;
  logic          do_push;
  logic          do_pop;
  logic          ovf_ev;
  logic          unf_ev;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign push  = ENABLE & ~RW;
  assign rd_en = ENABLE & RW;
  assign pop   = rd_en & ~PEEK;
  assign peek  = rd_en & PEEK;

  assign EMPTY = (level_q == '0);
  assign FULL  = (level_q == LVL_MAX);

  assign do_push = push & ~FULL;
  assign do_pop  = pop & ~EMPTY;
  assign ovf_ev  = push & FULL;
  assign unf_ev  = (pop | peek) & EMPTY;

  assign wr_idx = level_q[IW-1:0];
  assign rd_idx = wr_idx - 1'b1;

  assign TOP   = EMPTY ? '0 : mem[rd_idx];
  assign LEVEL = level_q;

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

  // TOP is already zero when empty, so an empty read drives zeros.
  assign DATA = rd_en ? TOP : 'z;

  always_ff @(posedge CLOCK) begin
    if (RESET && do_push) begin
      mem[wr_idx] <= DATA;
    end
  end

  // An error event in the same cycle as CLEAR_ERR leaves the flag set.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop) begin
        level_q <= level_q - 1'b1;
      end
      if (ovf_ev) begin
        ovf_q <= 1'b1;
      end else if (CLEAR_ERR) begin
        ovf_q <= 1'b0;
      end
      if (unf_ev) begin
        unf_q <= 1'b1;
      end else if (CLEAR_ERR) begin
        unf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bidi_stack_register.sv
// Scoreboard bench for bidi_stack_register.
// Stimulus queues tagged expectations; a negedge monitor checks them.
module tb_bidi_stack_register;

  localparam int BW = 16;
  localparam int PW = 4;

  localparam int S_DATA  = 0;
  localparam int S_TOP   = 1;
  localparam int S_LVL   = 2;
  localparam int S_FULL  = 3;
  localparam int S_EMPTY = 4;
  localparam int S_OVF   = 5;
  localparam int S_UNF   = 6;

  localparam logic [BW-1:0] IDLE_PAT = 16'h5A5A;

  logic          CLOCK;
  logic          RESET;
  logic          RW;
  logic          ENABLE;
  logic          PEEK;
  logic          CLEAR_ERR;
  wire  [BW-1:0] DATA;
  logic [BW-1:0] TOP;
  logic [PW-1:0] LEVEL;
  logic          FULL;
  logic          EMPTY;
  logic          OVERFLOW;
  logic          UNDERFLOW;

  logic          bus_oe;
  logic [BW-1:0] bus_drv;

  assign DATA = bus_oe ? bus_drv : 'z;

  bidi_stack_register #(
    .BUS_WIDTH(BW),
    .DEPTH    (8),
    .PTR_WIDTH(PW)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .RW       (RW),
    .ENABLE   (ENABLE),
    .PEEK     (PEEK),
    .CLEAR_ERR(CLEAR_ERR),
    .DATA     (DATA),
    .TOP      (TOP),
    .LEVEL    (LEVEL),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .OVERFLOW (OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  typedef struct {
    int            cyc;
    int            sel;
    logic [BW-1:0] v;
    string         nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  function automatic logic [BW-1:0] actual(input int sel);
    logic [BW-1:0] a;
    a = '0;
    case (sel)
      S_DATA:  a = DATA;
      S_TOP:   a = TOP;
      S_LVL:   a = BW'(LEVEL);
      S_FULL:  a = BW'(FULL);
      S_EMPTY: a = BW'(EMPTY);
      S_OVF:   a = BW'(OVERFLOW);
      S_UNF:   a = BW'(UNDERFLOW);
      default: a = 'x;
    endcase
    return a;
  endfunction

  always @(negedge CLOCK) begin
    logic [BW-1:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].sel);
        checks++;
        if (act !== sb[i].v) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %h, expected %h",
                   sb[i].nm, cyc, act, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic ex(input int off, input int sel,
                    input logic [BW-1:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + off;
    e.sel = sel;
    e.v   = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic drive(input bit en, input bit rw, input bit pk,
                       input bit clr, input bit rst,
                       input logic [BW-1:0] d);
    @(posedge CLOCK);
    #1;
    ENABLE    = en;
    RW        = rw;
    PEEK      = pk;
    CLEAR_ERR = clr;
    RESET     = rst;
    bus_drv   = d;
    bus_oe    = ~(en & rw);
  endtask

  task automatic push(input logic [BW-1:0] v);
    drive(1, 0, 0, 0, 1, v);
  endtask

  task automatic pop();
    drive(1, 1, 0, 0, 1, '0);
  endtask

  task automatic peek();
    drive(1, 1, 1, 0, 1, '0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1, IDLE_PAT);
  endtask

  initial begin
    RESET     = 1'b0;
    RW        = 1'b0;
    ENABLE    = 1'b0;
    PEEK      = 1'b0;
    CLEAR_ERR = 1'b0;
    bus_oe    = 1'b0;
    bus_drv   = '0;

    // reset state
    drive(0, 0, 0, 0, 0, IDLE_PAT);
    drive(0, 0, 0, 0, 0, IDLE_PAT);
    idle();
    ex(0, S_LVL, 16'd0, "rst_level");
    ex(0, S_EMPTY, 16'd1, "rst_empty");
    ex(0, S_FULL, 16'd0, "rst_full");
    ex(0, S_TOP, 16'h0000, "rst_top");
    ex(0, S_OVF, 16'd0, "rst_ovf");
    ex(0, S_UNF, 16'd0, "rst_unf");
    ex(0, S_DATA, IDLE_PAT, "rst_bus_z");

    // LIFO order
    push(16'h1111);
    ex(1, S_LVL, 16'd1, "p1_level");
    ex(1, S_TOP, 16'h1111, "p1_top");
    push(16'h2222);
    ex(1, S_LVL, 16'd2, "p2_level");
    push(16'h3333);
    ex(1, S_LVL, 16'd3, "p3_level");
    ex(1, S_TOP, 16'h3333, "p3_top");
    idle();
    ex(0, S_DATA, IDLE_PAT, "idle_bus_z");
    ex(1, S_LVL, 16'd3, "idle_level");
    pop();
    ex(0, S_DATA, 16'h3333, "pop1_data");
    ex(1, S_LVL, 16'd2, "pop1_level");
    pop();
    ex(0, S_DATA, 16'h2222, "pop2_data");
    ex(1, S_LVL, 16'd1, "pop2_level");
    pop();
    ex(0, S_DATA, 16'h1111, "pop3_data");
    ex(1, S_LVL, 16'd0, "pop3_level");
    ex(1, S_EMPTY, 16'd1, "pop3_empty");

    // fill and overflow
    for (int i = 1; i <= 8; i++) push(BW'(i));
    ex(1, S_FULL, 16'd1, "fill_full");
    ex(1, S_LVL, 16'd8, "fill_level");
    push(16'hBEEF);
    ex(1, S_LVL, 16'd8, "ovf_level");
    ex(1, S_OVF, 16'd1, "ovf_flag");
    ex(1, S_TOP, 16'h0008, "ovf_top");
    ex(1, S_FULL, 16'd1, "ovf_full");
    pop();
    ex(0, S_DATA, 16'h0008, "ovf_pop_data");
    ex(1, S_LVL, 16'd7, "ovf_pop_level");
    ex(1, S_FULL, 16'd0, "ovf_pop_full");
    drive(0, 0, 0, 1, 1, IDLE_PAT);
    ex(1, S_OVF, 16'd0, "ovf_clear");

    // alternating push/pop at DEPTH-1
    push(16'h7777);
    ex(1, S_FULL, 16'd1, "alt_full");
    pop();
    ex(0, S_DATA, 16'h7777, "alt_pop1");
    push(16'h6666);
    pop();
    ex(0, S_DATA, 16'h6666, "alt_pop2");
    ex(1, S_OVF, 16'd0, "alt_no_ovf");
    ex(1, S_LVL, 16'd7, "alt_level");
    for (int i = 7; i >= 1; i--) begin
      pop();
      ex(0, S_DATA, BW'(i), $sformatf("drain_%0d", i));
    end
    idle();
    ex(0, S_EMPTY, 16'd1, "drain_empty");

    // underflow and CLEAR_ERR priority
    pop();
    ex(0, S_DATA, 16'h0000, "unf_data");
    ex(1, S_UNF, 16'd1, "unf_flag");
    ex(1, S_LVL, 16'd0, "unf_level");
    drive(1, 1, 0, 1, 1, '0);
    ex(1, S_UNF, 16'd1, "unf_set_wins");
    drive(0, 0, 0, 1, 1, IDLE_PAT);
    ex(1, S_UNF, 16'd0, "unf_clear");

    // peek
    push(16'hA5A5);
    peek();
    ex(0, S_DATA, 16'hA5A5, "peek1_data");
    ex(1, S_LVL, 16'd1, "peek1_level");
    peek();
    ex(0, S_DATA, 16'hA5A5, "peek2_data");
    ex(1, S_LVL, 16'd1, "peek2_level");
    pop();
    ex(0, S_DATA, 16'hA5A5, "peek_pop_data");
    ex(1, S_LVL, 16'd0, "peek_pop_level");
    peek();
    ex(0, S_DATA, 16'h0000, "peek_empty_data");
    ex(1, S_UNF, 16'd1, "peek_empty_unf");
    ex(1, S_LVL, 16'd0, "peek_empty_level");
    drive(0, 0, 0, 1, 1, IDLE_PAT);
    ex(1, S_UNF, 16'd0, "peek_unf_clear");

    // reset during a push
    for (int i = 1; i <= 5; i++) push(16'h0100 + BW'(i));
    ex(1, S_LVL, 16'd5, "pre_rst_level");
    ex(1, S_TOP, 16'h0105, "pre_rst_top");
    drive(1, 0, 0, 0, 0, 16'hDEAD);
    ex(1, S_LVL, 16'd0, "mid_rst_level");
    ex(1, S_EMPTY, 16'd1, "mid_rst_empty");
    ex(1, S_TOP, 16'h0000, "mid_rst_top");
    idle();
    ex(0, S_DATA, IDLE_PAT, "post_rst_bus_z");
    push(16'h1234);
    ex(1, S_TOP, 16'h1234, "post_rst_top");
    ex(1, S_LVL, 16'd1, "post_rst_level");

    idle();
    idle();
    idle();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked, expected 0",
               sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidi_stack_register.md
Name: bidi_stack_register

Overview:
Parametrised bus-attached LIFO: the successor to the single bidirectional register, generalised from one word to DEPTH words. It sits on the shared tristate data bus (for example, as the hardware call/return or operand stack) and uses the same RW/ENABLE bus protocol. A bus write pushes a word and a bus read pops a word. It adds peek, occupancy and full/empty flags, and sticky overflow/underflow error flags.

Parameters:
BUS_WIDTH, 16, width of each stack word and of DATA/TOP
DEPTH, 8, number of stack entries (>=2)
PTR_WIDTH, 4, width of LEVEL; must satisfy 2^PTR_WIDTH > DEPTH

Ports:
CLOCK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous reset, active-low
RW  input  1  high = bus read (pop/peek), low = bus write (push)
ENABLE  input  1  bus access enable, active high
PEEK  input  1  when high during a bus read, drive the top word without popping
CLEAR_ERR  input  1  clears OVERFLOW/UNDERFLOW, active high
DATA  inout  BUS_WIDTH  shared tristate data bus
TOP  output  BUS_WIDTH  continuous top-of-stack word (0 when empty)
LEVEL  output  PTR_WIDTH  number of valid entries, 0..DEPTH
FULL  output  1  LEVEL == DEPTH
EMPTY  output  1  LEVEL == 0
OVERFLOW  output  1  sticky: a push was attempted while full
UNDERFLOW  output  1  sticky: a pop or peek was attempted while empty

Behaviour:
- Reset: RESET is synchronous and active-low on CLOCK. While RESET is low at a rising edge: LEVEL<=0, OVERFLOW<=0, UNDERFLOW<=0. Storage contents are don't-care. After reset, TOP=0, EMPTY=1, FULL=0. Reset overrides all other operations in the same cycle.
- Operation decode (priority after reset):
  - push = ENABLE & ~RW
  - pop = ENABLE & RW & ~PEEK
  - peek = ENABLE & RW & PEEK
  - push, pop and peek are mutually exclusive by construction.
- Push, not full: mem[LEVEL] <= DATA; LEVEL <= LEVEL+1. The new word is visible on TOP the next cycle.
- Push, full: storage and LEVEL are unchanged; OVERFLOW <= 1. There is no wrap and no overwrite of the top entry.
- Pop, not empty: DATA is driven combinationally with TOP for the whole cycle (mem[LEVEL-1]); LEVEL <= LEVEL-1 at the edge.
- Pop, empty: DATA is driven with all-zeros; LEVEL stays 0; UNDERFLOW <= 1.
- Peek: DATA is driven with TOP; LEVEL is unchanged. Peek while empty drives zeros and sets UNDERFLOW.
- Bus drive: DATA = TOP only when ENABLE & RW, otherwise all-Z. The block never drives the bus during a push or when ENABLE is low.
- TOP, LEVEL, FULL and EMPTY are combinational from registered state. Latency: 0 cycles for read data, 1 cycle for the state update.
- CLEAR_ERR: at the edge, clears both sticky flags. If an error event occurs in the same cycle, the set wins (the flag reads 1 afterwards).
- Back-to-back operations are allowed every cycle. Push then pop on consecutive cycles returns the pushed word. Alternating push/pop at LEVEL=DEPTH-1 must not set FULL-related errors.
- The pointer never wraps. LEVEL saturates at 0 and at DEPTH via the error rules above.
- ENABLE low: no state change; errors hold.

Test Plan:
1. Hold RESET low for 2 cycles, then release with ENABLE=0 -> LEVEL=0, EMPTY=1, FULL=0, TOP=0, OVERFLOW=UNDERFLOW=0, DATA=Z.
2. Push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop 3 times -> DATA reads 0x3333, 0x2222, 0x1111 during each pop cycle; LEVEL steps 3,2,1,0; EMPTY=1 at the end.
3. Push DEPTH words (0x0001..0x0008), then push 0xBEEF -> FULL=1, LEVEL=8, OVERFLOW=1, TOP=0x0008 (0xBEEF is discarded); then pop -> 0x0008.
4. From empty, pop once -> DATA=0x0000, UNDERFLOW=1, LEVEL=0. Then assert CLEAR_ERR together with a second empty pop -> UNDERFLOW stays 1. Then CLEAR_ERR alone -> UNDERFLOW=0.
5. Push 0xA5A5, then peek twice -> DATA=0xA5A5 both cycles, LEVEL stays 1. Then pop -> 0xA5A5, LEVEL=0.
6. Fill to LEVEL=5, then assert RESET low for one cycle in the middle of a push -> LEVEL=0, EMPTY=1, TOP=0, the push is lost, and the bus is Z on the following idle cycle.
